// File: rtl/apb_alu_unit_if.sv
// APB3 bus bundle for the ALU slave: master drives request fields, slave returns response fields.
interface apb_alu_unit_if #(
  parameter int DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [2:0]        paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_alu_unit.sv
// APB3 slave ALU: operand/ctrl registers, single-cycle add/sub/logic/shift, iterative shift-add MUL.
// Responses are registered, so every transfer has one wait state; RESULT reads stall while busy.
module apb_alu_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input logic            pclk,
  input logic            preset,
  apb_alu_unit_if.slave  apb
);

  localparam int SH_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_WAIT
  } apb_state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  apb_state_e state, state_nxt;

  logic [DATA_W-1:0]   reg_a, reg_b, result;
  logic [DATA_W-1:0]   opa, opb;
  op_e                 op_q;
  logic                flag_z, flag_n, flag_c, flag_v;
  logic                busy, start;
  logic [SH_W-1:0]     mul_cnt;
  logic [2*DATA_W-1:0] mcand, prod, prod_nxt;
  logic [DATA_W-1:0]   mplier;
  logic [CNT_W-1:0]    opcnt;

  logic                access, stall, fire, err, wr;
  logic [DATA_W-1:0]   rdata;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c, alu_v;
  logic                mul_last, done;

  assign access   = apb.psel & apb.penable;
  assign stall    = !apb.pwrite && (apb.paddr == 3'd3) && busy;
  assign mul_last = busy && (mul_cnt == '0);
  assign done     = start | mul_last;

  // APB state register
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (apb.psel && !apb.penable) state_nxt = S_SETUP;
      S_SETUP: begin
        if (!apb.psel)       state_nxt = S_IDLE;
        else if (apb.penable) state_nxt = stall ? S_WAIT : S_ACCESS;
      end
      S_ACCESS: state_nxt = S_IDLE;
      S_WAIT: begin
        if (!apb.psel)  state_nxt = S_IDLE;
        else if (!busy) state_nxt = S_ACCESS;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Transfer completion decode and read mux
  always_comb begin
    fire  = 1'b0;
    err   = 1'b0;
    rdata = '0;
    if (state == S_SETUP && access && !stall) fire = 1'b1;
    if (state == S_WAIT && access && !busy)   fire = 1'b1;
    if (apb.paddr >= 3'd6) err = 1'b1;
    if (apb.pwrite && (apb.paddr == 3'd3 || apb.paddr == 3'd4)) err = 1'b1;
    if (apb.pwrite && busy && apb.paddr <= 3'd2) err = 1'b1;
    case (apb.paddr)
      3'd0: begin
        rdata[DATA_W-1] = busy;
        rdata[2:0]      = op_q;
      end
      3'd1:    rdata = reg_a;
      3'd2:    rdata = reg_b;
      3'd3:    rdata = result;
      3'd4:    rdata[4:0] = {busy, flag_v, flag_c, flag_n, flag_z};
      3'd5:    rdata[CNT_W-1:0] = opcnt;
      default: rdata = '0;
    endcase
    wr = fire && apb.pwrite && !err;
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      apb.pready  <= 1'b0;
      apb.pslverr <= 1'b0;
      apb.prdata  <= '0;
    end else begin
      apb.pready  <= fire;
      apb.pslverr <= fire & err;
      if (fire && err)              apb.prdata <= '0;
      else if (fire && !apb.pwrite) apb.prdata <= rdata;
    end
  end

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_q)
      OP_ADD: begin
        {alu_c, alu_res} = {1'b0, opa} + {1'b0, opb};
        alu_v = (opa[DATA_W-1] == opb[DATA_W-1]) && (alu_res[DATA_W-1] != opa[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res = opa - opb;
        alu_c   = opa < opb;
        alu_v   = (opa[DATA_W-1] != opb[DATA_W-1]) && (alu_res[DATA_W-1] != opa[DATA_W-1]);
      end
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      OP_XOR:  alu_res = opa ^ opb;
      OP_SHL:  alu_res = opa << opb[SH_W-1:0];
      OP_SHR:  alu_res = opa >> opb[SH_W-1:0];
      default: alu_res = '0;
    endcase
  end

  assign prod_nxt = prod + (mplier[0] ? mcand : '0);

  // Registers and execution; MUL is launched straight from the CTRL write edge, other ops one edge later
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      reg_a   <= '0;
      reg_b   <= '0;
      result  <= '0;
      opa     <= '0;
      opb     <= '0;
      op_q    <= OP_ADD;
      flag_z  <= 1'b0;
      flag_n  <= 1'b0;
      flag_c  <= 1'b0;
      flag_v  <= 1'b0;
      busy    <= 1'b0;
      start   <= 1'b0;
      mul_cnt <= '0;
      mcand   <= '0;
      mplier  <= '0;
      prod    <= '0;
    end else begin
      start <= 1'b0;
      if (wr) begin
        case (apb.paddr)
          3'd0: begin
            op_q <= op_e'(apb.pwdata[2:0]);
            opa  <= reg_a;
            opb  <= reg_b;
            if (op_e'(apb.pwdata[2:0]) == OP_MUL) begin
              busy    <= 1'b1;
              mul_cnt <= SH_W'(DATA_W - 1);
              mcand   <= {{DATA_W{1'b0}}, reg_a};
              mplier  <= reg_b;
              prod    <= '0;
            end else begin
              start <= 1'b1;
            end
          end
          3'd1:    reg_a <= apb.pwdata;
          3'd2:    reg_b <= apb.pwdata;
          default: ;
        endcase
      end
      if (start) begin
        result <= alu_res;
        flag_z <= (alu_res == '0);
        flag_n <= alu_res[DATA_W-1];
        flag_c <= alu_c;
        flag_v <= alu_v;
      end
      if (busy) begin
        prod    <= prod_nxt;
        mcand   <= mcand << 1;
        mplier  <= mplier >> 1;
        mul_cnt <= mul_cnt - 1'b1;
        if (mul_last) begin
          busy   <= 1'b0;
          result <= prod_nxt[DATA_W-1:0];
          flag_z <= (prod_nxt[DATA_W-1:0] == '0);
          flag_n <= prod_nxt[DATA_W-1];
          flag_c <= (prod_nxt[2*DATA_W-1:DATA_W] != '0);
          flag_v <= (prod_nxt[2*DATA_W-1:DATA_W] != '0);
        end
      end
    end
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset)                      opcnt <= '0;
    else if (wr && apb.paddr == 3'd5) opcnt <= '0;
    else if (done)                    opcnt <= opcnt + 1'b1;
  end

endmodule
